// File: rtl/spi_mem_resp_pkg.sv
// spi_mem_resp_pkg: opcodes, FSM states and timing constants shared by the SPI memory responder
package spi_mem_resp_pkg;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam int MIN_SCK_PHASE = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_RD_DATA,
        S_WR_DATA,
        S_STATUS,
        S_IGNORE
    } state_t;
endpackage

// File: rtl/spi_resp_sync.sv
// spi_resp_sync: 2-flop synchronizer plus a registered previous value for edge detection
module spi_resp_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] sh;
    always_ff @(posedge clk)
        sh <= rst ? {3{RST_VAL}} : {sh[1:0], d};
    assign level = sh[1];
    assign rise  = sh[1] & ~sh[2];
    assign fall  = ~sh[1] & sh[2];
endmodule

// File: rtl/spi_mem_resp.sv
// spi_mem_resp: SPI mode-0 flash-like memory responder; define SPI_MEM_RESP_WEL_EN for the WREN/WRDI write-enable latch
module spi_mem_resp #(
    parameter int AW = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          spi_clk_o,
    input  logic          spi_do_o,
    input  logic          spi_sel_o,
    input  logic          spi_en,
    output logic          spi_di_i,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [7:0]    mem_wdata
);
    import spi_mem_resp_pkg::*;

    state_t      state, state_nx;
    logic        sck_lvl, sck_rise, sck_fall;
    logic        mosi, mosi_rise, mosi_fall;
    logic        sel, sel_rise, sel_fall;
    logic [2:0]  bit_cnt;
    logic [15:0] rx_sh;
    logic [7:0]  op, tx, tx_src, status, rx_byte;
    logic [15:0] addr_rx;
    logic        tx_load, wr_step, byte_done, we_ok, tx_bit;
    logic        unused;

    spi_resp_sync u_sck (.clk(wb_clk_i), .rst(wb_rst_i), .d(spi_clk_o), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_resp_sync u_mosi (.clk(wb_clk_i), .rst(wb_rst_i), .d(spi_do_o), .level(mosi), .rise(mosi_rise), .fall(mosi_fall));
    spi_resp_sync #(.RST_VAL(1'b1)) u_sel (.clk(wb_clk_i), .rst(wb_rst_i), .d(spi_sel_o | ~spi_en), .level(sel), .rise(sel_rise), .fall(sel_fall));

    assign unused    = ^{sck_lvl, mosi_rise, mosi_fall, sel_rise, sel_fall, rx_sh[15]};
    assign rx_byte   = {rx_sh[6:0], mosi};
    assign addr_rx   = {rx_sh[14:0], mosi};
    assign byte_done = sck_rise && bit_cnt == 3'd7 && !sel;
    assign tx_src    = state == S_STATUS ? status : tx;
    assign tx_bit    = tx_src[~bit_cnt];

`ifdef SPI_MEM_RESP_WEL_EN
    logic wel;
    always_ff @(posedge wb_clk_i)
        if (wb_rst_i)
            wel <= 1'b0;
        else if (sel && op == OP_WRITE)
            wel <= 1'b0;
        else if (byte_done && state == S_CMD && (rx_byte == OP_WREN || rx_byte == OP_WRDI))
            wel <= rx_byte == OP_WREN;
    assign we_ok  = wel;
    assign status = {6'b0, wel, 1'b0};
`else
    assign we_ok  = 1'b1;
    assign status = 8'h00;
`endif

    always_ff @(posedge wb_clk_i)
        state <= wb_rst_i ? S_IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (sel)
            state_nx = S_IDLE;
        else if (state == S_IDLE)
            state_nx = S_CMD;
        else if (byte_done)
            case (state)
                S_CMD:     state_nx = (rx_byte == OP_READ || rx_byte == OP_WRITE) ? S_ADDR_HI :
                                      rx_byte == OP_RDSR ? S_STATUS : S_IGNORE;
                S_ADDR_HI: state_nx = S_ADDR_LO;
                S_ADDR_LO: state_nx = op == OP_READ ? S_RD_DATA : S_WR_DATA;
                default:   state_nx = state;
            endcase
    end

    // Reads prefetch on the last bit of each byte so TX is loaded before the next SCK fall
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bit_cnt   <= '0;
            rx_sh     <= '0;
            op        <= '0;
            tx        <= '0;
            tx_load   <= 1'b0;
            wr_step   <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            spi_di_i  <= 1'b0;
        end else begin
            mem_rd  <= byte_done && ((state == S_ADDR_LO && op == OP_READ) || state == S_RD_DATA);
            mem_we  <= byte_done && state == S_WR_DATA && we_ok;
            wr_step <= byte_done && state == S_WR_DATA;
            tx_load <= mem_rd;
            if (tx_load)
                tx <= mem_rdata;
            if (state == S_IDLE) begin
                bit_cnt <= '0;
                op      <= '0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 1'b1;
                rx_sh   <= {rx_sh[14:0], mosi};
            end
            if (byte_done && state == S_CMD)
                op <= rx_byte;
            if (byte_done && state == S_ADDR_LO)
                mem_addr <= addr_rx[AW-1:0];
            else if (wr_step || (byte_done && state == S_RD_DATA))
                mem_addr <= mem_addr + 1'b1;
            if (byte_done && state == S_WR_DATA)
                mem_wdata <= rx_byte;
            spi_di_i <= (state == S_RD_DATA || state == S_STATUS) ? (sck_fall ? tx_bit : spi_di_i) : 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_mem_resp.sv
// tb_spi_mem_resp: table, directed and randomized checks of spi_mem_resp against a transaction-level model
module tb_spi_mem_resp;
`ifdef SPI_MEM_RESP_WEL_EN
    localparam bit WEL_EN = 1'b1;
`else
    localparam bit WEL_EN = 1'b0;
`endif
    localparam int HALF = 6;

    logic        clk = 1'b0, rst = 1'b1;
    logic        sck = 1'b0, mosi = 1'b0, sel = 1'b1, en = 1'b1;
    logic        miso, mem_rd, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00, mem_wdata;

    logic [7:0]  mem [65536];
    logic [7:0]  mdl [65536];
    logic [15:0] rd_log[$];
    logic [23:0] wr_log[$];
    logic [7:0]  txq[$], rxq[$], exp_rx[$];
    logic [23:0] exp_w[$];
    int          errors = 0, checks = 0, overlap = 0;

    typedef struct {
        logic [7:0] pre;
        logic [7:0] op;
        logic [7:0] exp_def;
        logic [7:0] exp_und;
    } vec_t;
    vec_t tbl[7];

    spi_mem_resp #(.AW(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .spi_clk_o(sck), .spi_do_o(mosi), .spi_sel_o(sel), .spi_en(en),
        .spi_di_i(miso), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // The memory lives in the bench: strobes are serviced and logged on every falling clock edge
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (mem_rd) begin
                mem_rdata = mem[mem_addr];
                rd_log.push_back(mem_addr);
            end
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wr_log.push_back({mem_addr, mem_wdata});
            end
            if (mem_rd && mem_we) overlap++;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - n; i--) begin
            mosi = tx[i];
            tick(HALF);
            rx[i] = miso;
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic cs_on();
        sel = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_off();
        tick(HALF);
        sel = 1'b1;
        tick(8);
    endtask

    task automatic run();
        logic [7:0] r;
        rxq.delete();
        cs_on();
        foreach (txq[i]) begin
            spi_bits(txq[i], 8, r);
            rxq.push_back(r);
        end
        cs_off();
    endtask

    task automatic clr_logs();
        rd_log.delete();
        wr_log.delete();
    endtask

    initial begin
        logic [7:0]  r, d;
        logic [15:0] a;
        int          kind, n, base;
        bit          wel_m;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        tick(4);
        chk("rst_miso", {31'd0, miso}, 0);
        chk("rst_rd", {31'd0, mem_rd}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr", {16'd0, mem_addr}, 0);
        chk("rst_wdata", {24'd0, mem_wdata}, 0);
        rst = 1'b0;
        tick(4);

        tbl[0] = '{8'h00, 8'h05, 8'h00, 8'h00};
        tbl[1] = '{8'h06, 8'h05, 8'h02, 8'h00};
        tbl[2] = '{8'h04, 8'h05, 8'h00, 8'h00};
        tbl[3] = '{8'h06, 8'h9F, 8'h00, 8'h00};
        tbl[4] = '{8'h00, 8'h05, 8'h02, 8'h00};
        tbl[5] = '{8'h04, 8'h00, 8'h00, 8'h00};
        tbl[6] = '{8'h00, 8'h05, 8'h00, 8'h00};
        foreach (tbl[k]) begin
            clr_logs();
            if (tbl[k].pre != 8'h00) begin
                txq = '{tbl[k].pre};
                run();
            end
            txq = '{tbl[k].op, 8'h00, 8'h00};
            run();
            chk($sformatf("tbl%0d_b0", k), rxq[1], WEL_EN ? tbl[k].exp_def : tbl[k].exp_und);
            chk($sformatf("tbl%0d_b1", k), rxq[2], WEL_EN ? tbl[k].exp_def : tbl[k].exp_und);
            chk($sformatf("tbl%0d_strobes", k), rd_log.size() + wr_log.size(), 0);
        end

        clr_logs();
        txq = '{8'h06};
        run();
        txq = '{8'h02, 8'h12, 8'h34, 8'hA5, 8'h5A};
        run();
        chk("wr_count", wr_log.size(), 2);
        chk("wr0", wr_log[0], 24'h1234A5);
        chk("wr1", wr_log[1], 24'h12355A);
        txq = '{8'h05, 8'h00};
        run();
        chk("wel_after_write", rxq[1], 8'h00);

        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h0001] = 8'h99;
        clr_logs();
        txq = '{8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00};
        run();
        chk("rd_wrap_b0", rxq[3], 8'h11);
        chk("rd_wrap_b1", rxq[4], 8'h22);
        chk("rd_addr_count", rd_log.size(), 3);
        chk("rd_addr0", rd_log[0], 16'hFFFF);
        chk("rd_addr1", rd_log[1], 16'h0000);
        chk("rd_addr2", rd_log[2], 16'h0001);

        clr_logs();
        txq = '{8'h02, 8'h20, 8'h00, 8'h77};
        run();
        chk("wr_no_wren", wr_log.size(), WEL_EN ? 0 : 1);

        mem[16'h0100] = 8'h3C;
        txq = '{8'h06};
        run();
        clr_logs();
        cs_on();
        spi_bits(8'h02, 8, r);
        spi_bits(8'h01, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'hF0, 4, r);
        cs_off();
        chk("partial_wr", wr_log.size(), 0);
        txq = '{8'h03, 8'h01, 8'h00, 8'h00};
        run();
        chk("rd_after_partial", rxq[3], 8'h3C);

        en = 1'b0;
        clr_logs();
        txq = '{8'h03, 8'h00, 8'h00, 8'h00};
        run();
        chk("en_low_no_rd", rd_log.size(), 0);
        en = 1'b1;
        tick(8);

        mem[16'h0040] = 8'hFF;
        mem[16'h0041] = 8'hFF;
        cs_on();
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h40, 8, r);
        spi_bits(8'h00, 4, r);
        tick(HALF);
        chk("mid_read_miso", {31'd0, miso}, 1);
        chk("mid_read_addr", {16'd0, mem_addr}, 32'h40);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_read", {7'd0, miso, mem_rd, mem_we, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        sel = 1'b1;
        tick(10);
        txq = '{8'h03, 8'h00, 8'h40, 8'h00};
        run();
        chk("rd_after_rst", rxq[3], 8'hFF);

        for (int i = 0; i < 65536; i++) mdl[i] = mem[i];
        txq = '{8'h04};
        run();
        wel_m = 1'b0;
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 4);
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            n = $urandom_range(1, 3);
            exp_rx.delete();
            exp_w.delete();
            clr_logs();
            case (kind)
                0: begin
                    txq = '{8'h03, a[15:8], a[7:0]};
                    for (int j = 0; j < n; j++) begin
                        txq.push_back(8'h00);
                        exp_rx.push_back(mdl[16'(a + j)]);
                    end
                end
                1: begin
                    txq = '{8'h02, a[15:8], a[7:0]};
                    for (int j = 0; j < n; j++) begin
                        d = 8'($urandom);
                        txq.push_back(d);
                        if (wel_m || !WEL_EN) begin
                            exp_w.push_back({16'(a + j), d});
                            mdl[16'(a + j)] = d;
                        end
                    end
                    wel_m = 1'b0;
                end
                2: begin
                    txq = '{8'h06};
                    wel_m = WEL_EN;
                end
                3: begin
                    txq = '{8'h04};
                    wel_m = 1'b0;
                end
                default: begin
                    txq = '{8'h05};
                    for (int j = 0; j < n; j++) begin
                        txq.push_back(8'h00);
                        exp_rx.push_back({6'b0, wel_m, 1'b0});
                    end
                end
            endcase
            run();
            base = rxq.size() - exp_rx.size();
            foreach (exp_rx[j]) chk($sformatf("rnd%0d_rx%0d", t, j), rxq[base + j], exp_rx[j]);
            chk($sformatf("rnd%0d_wcount", t), wr_log.size(), exp_w.size());
            foreach (exp_w[j])
                if (j < wr_log.size()) chk($sformatf("rnd%0d_w%0d", t, j), wr_log[j], exp_w[j]);
        end

        chk("rd_we_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_mem_resp.md
# spi_mem_resp

Synthesizable SPI mode-0 responder: the target end of the SPI master bus (`spi_clk_o`, `spi_do_o`, `spi_sel_o`, `spi_en` in, `spi_di_i` out).
- Decodes a small flash-like command set and serves reads and writes from a byte-wide memory port in the system clock domain.
- Used in the bench and on-chip as the far end of the SPI controller, so the controller can be exercised end-to-end.

## Interface
Parameters:
- `AW`, 16: memory address width; the address phase is always two bytes, and only the low `AW` bits are used.

Ports:
- `wb_clk_i` in 1: system clock; all logic is on this edge.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `spi_clk_o` in 1: SCK from the master; asynchronous to `wb_clk_i`.
- `spi_do_o` in 1: MOSI from the master.
- `spi_sel_o` in 1: chip select from the master, active-low.
- `spi_en` in 1: master bus enable. Low is treated as deselected.
- `spi_di_i` out 1: MISO to the master.
- `mem_addr` out AW: memory byte address.
- `mem_rd` out 1: one-cycle read strobe. `mem_rdata` is valid the next cycle.
- `mem_rdata` in 8: read data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_wdata` out 8: write data; valid while `mem_we` is high.

## Operation
- **Input synchronisation:** SCK, MOSI and `sel = spi_sel_o | ~spi_en` each pass through a 2-flop synchronizer. Edge detection uses a third flop.
- **Bit timing:** MSB first.
  - MOSI is sampled on the synced SCK rising edge.
  - MISO is updated on the synced SCK falling edge.
- **Transaction start:** a synced `sel` falling edge (or `sel` low out of reset) enters CMD with the bit counter at 0.
- **States:**
  - IDLE: `sel` high.
  - CMD: collects the opcode.
  - ADDR_HI, ADDR_LO: collect the address bytes.
  - RD_DATA, WR_DATA: data phase.
  - STATUS: returns the status byte.
  - IGNORE: discards bits until deselect.
- **Transitions after the 8th opcode bit:**
  - 0x03 READ → ADDR_HI.
  - 0x02 WRITE → ADDR_HI.
  - 0x05 RDSR → STATUS.
  - 0x06 WREN → IGNORE.
  - 0x04 WRDI → IGNORE.
  - Any other opcode → IGNORE.
  - After ADDR_LO, the state goes to RD_DATA or WR_DATA according to the latched opcode.
- **READ:**
  - `mem_rd` pulses with `mem_addr` = received address in the cycle after the rising edge of the last address bit.
  - `mem_rdata` loads the TX shift register.
  - On each subsequent falling edge, the next bit goes out, bit 7 first.
  - On the rising edge of bit 0 of every data byte, the address increments and `mem_rd` pulses again (prefetch).
  - The address wraps from 2^AW−1 to 0.
- **WRITE:**
  - Each complete received byte produces a one-cycle `mem_we` with the current `mem_addr`, then the address increments with wrap.
  - The write is suppressed when the write-enable check fails (see Configuration).
  - A partial byte at deselect is discarded.
- **STATUS:** shifts out {6'b0, WEL, 1'b0}, then repeats it for as long as SCK runs.
- **MISO:** drives 0 in IDLE, CMD, ADDR_HI, ADDR_LO and IGNORE.
- **Deselect at any point:** the state returns to IDLE within 3 cycles of the `spi_sel_o` rising edge. Partial bytes are discarded, and no `mem_rd` or `mem_we` is issued after that.
- **Reset values:** `spi_di_i` = 0, `mem_rd` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, state = IDLE, WEL = 0. Reset mid-transaction discards everything; the next `sel` falling edge starts cleanly.

## Timing
- SCK high and low phases must each be at least 4 `wb_clk_i` cycles. CS setup and hold relative to SCK must be at least 4 cycles.
- A SCK edge is seen on the bus-side logic 3 cycles after the pin edge.
- `spi_di_i` changes 1 cycle after the synced falling edge, i.e. at most 4 cycles after the pin edge.
- Read path: `mem_rd` fires 1 cycle after the synced rising edge, and TX is loaded 2 cycles after it. This completes before the next synced falling edge, given the 4-cycle minimum phase.
- `mem_we` fires 1 cycle after the synced rising edge of bit 0.
- `mem_rd` and `mem_we` are never high in the same cycle.

## Configuration
- The macro is `SPI_MEM_RESP_WEL_EN`.
- **Defined:**
  - 0x06 sets WEL and 0x04 clears it, each taking effect when the opcode completes.
  - WRITE data bytes are committed only if WEL = 1.
  - WEL clears on deselect after any WRITE transaction.
  - RDSR bit 1 reports WEL.
- **Undefined:**
  - There is no WEL register; writes are always committed.
  - 0x06 and 0x04 are unknown opcodes and go to IGNORE.
  - The status byte is 0x00.

## Structure
- **Shared package `spi_mem_resp_pkg`:**
  - Opcode constants: `OP_READ`, `OP_WRITE`, `OP_RDSR`, `OP_WREN`, `OP_WRDI`.
  - State enum type.
  - Minimum SCK phase constant (4).
- **Sub-module `spi_resp_sync`:**
  - Instantiated three times, for SCK, MOSI and sel.
  - Provides a 2-flop synchronizer plus a registered previous value.
  - Outputs `level`, `rise` and `fall`.

## Test plan
- WREN, then WRITE 0x02 addr 0x1234 data 0xA5 0x5A, then deselect → `mem_we` at 0x1234 = 0xA5 and 0x1235 = 0x5A; WEL = 0 afterwards.
- Memory preloaded 0x11 at 0xFFFF and 0x22 at 0x0000; READ 0x03 addr 0xFFFF for 2 bytes → MISO returns 0x11 then 0x22; `mem_rd` addresses are 0xFFFF, 0x0000, 0x0001.
- WRITE without a preceding WREN (macro defined) → no `mem_we`. Same sequence with the macro undefined → `mem_we` fires.
- WREN then RDSR → MISO = 0x02 (macro defined), 0x00 (undefined).
- WRITE, deselect after 4 data bits → no `mem_we`; the next READ at the same address works normally.
- Opcode 0x9F with 16 clocks → MISO stays 0 and no memory strobes. Assert `wb_rst_i` mid-READ → outputs return to reset values on the next cycle.
